tile_scheduler: RTL
===================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameter M, default 3: number of input channels.
REQ-002 Parameter W, default 512: image width in pixels.
REQ-003 Parameter H, default 512: image height in pixels.
REQ-004 Parameter n, default 4: input tile size; stride S = n-2; TILES_X = (W-n)/S+1; TILES_Y = (H-n)/S+1; TILE_BITS = M*n*n*8.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 i_clk  input  1  clock; all logic on the rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_start  input  1  one-cycle frame start request.
REQ-009 i_tile_valid  input  1  tile strobe from the input control unit ready output.
REQ-010 i_tile_data  input  TILE_BITS  tile from the input control unit.
REQ-011 i_engine_ready  input  1  processing engine accepts a tile.
REQ-012 i_engine_idle  input  1  engine pipeline empty.
REQ-013 o_tile_valid  output  1  held tile valid to the engine.
REQ-014 o_tile_data  output  TILE_BITS  held tile.
REQ-015 o_tile_col  output  16  tile column index.
REQ-016 o_tile_row  output  16  tile row index.
REQ-017 o_last  output  1  high with the final tile of the frame.
REQ-018 o_proc_finish  output  1  one-cycle frame-end pulse; drives proc_finish of the input control unit.
REQ-019 o_busy  output  1  high in RUN and FLUSH.
REQ-020 o_overflow  output  1  sticky dropped-tile flag.
REQ-021 o_stall_cycles  output  32  engine back-pressure cycle count.

Function
REQ-022 FSM states IDLE, RUN, FLUSH, DONE; transitions occur only as listed below.
- IDLE -> RUN on i_start; clears col/row counters, holding register and o_overflow.
- RUN -> FLUSH on transfer of the last tile.
- FLUSH -> DONE when i_engine_idle is 1.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-023 Transfer is defined as o_tile_valid && i_engine_ready.
- o_tile_data, o_tile_col and o_tile_row stay stable while o_tile_valid && !i_engine_ready.
REQ-024 Capture in RUN: i_tile_valid loads a 1-entry holding register when the register is empty or a transfer occurs in the same cycle.
- o_tile_valid rises the cycle after capture (latency 1).
- Capture plus transfer in the same cycle sustains 1 tile/cycle.
REQ-025 Overflow: i_tile_valid in RUN with the register full and no transfer drops the tile, sets o_overflow, and leaves the counters unchanged.
REQ-026 Counters advance on transfer.
- col wraps from TILES_X-1 to 0; row increments on the wrap.
- o_tile_col/o_tile_row show the index of the held tile.
REQ-027 o_last = o_tile_valid && row==TILES_Y-1 && col==TILES_X-1.
REQ-028 i_tile_valid in IDLE, FLUSH or DONE is ignored: no capture, no count, no overflow.
REQ-029 i_start outside IDLE is ignored.
REQ-030 o_proc_finish is high exactly on the DONE cycle.
REQ-031 o_busy = 1 in RUN and FLUSH, 0 in IDLE and DONE.
REQ-032 o_overflow holds until the next accepted i_start or reset.

Reset
REQ-033 i_rst is sampled at the clock edge and overrides all other inputs, including mid-frame.
- State returns to IDLE; holding register is emptied.
- o_tile_valid, o_tile_data, o_tile_col, o_tile_row, o_last, o_proc_finish, o_busy, o_overflow and o_stall_cycles are all 0 on the cycle after the reset edge.
- No o_proc_finish is generated by a reset.

Configuration
REQ-034 Macro TILE_SCHEDULER_PERF_EN.
- Defined: o_stall_cycles increments by 1 on every cycle with o_tile_valid && !i_engine_ready; saturates at 2^32-1; clears on accepted i_start.
- Undefined: o_stall_cycles is tied to 0 and no counter logic is built; all other behaviour is identical.

Verification (W=8, H=8, n=4, M=3 -> TILES_X=3, TILES_Y=3)
REQ-035 Reset then i_start with 9 tiles and i_engine_ready=1 -> 9 transfers, (row,col) from (0,0) to (2,2); o_last only with (2,2); o_busy=1 throughout.
REQ-036 i_engine_ready=0 for 5 cycles while a tile is held -> o_tile_data stable for those 5 cycles; o_stall_cycles=5 with the macro, 0 without.
REQ-037 Second i_tile_valid while held and not ready -> o_overflow=1; the dropped tile is never presented; counters are unchanged.
REQ-038 Last tile transferred, i_engine_idle low for 3 cycles then high -> state FLUSH for 4 cycles, then o_proc_finish=1 for exactly 1 cycle, then IDLE.
REQ-039 i_rst asserted after 4 transfers -> all outputs 0 next cycle; a new i_start restarts at (0,0) with o_overflow=0.
REQ-040 i_tile_valid in IDLE and i_start during RUN -> no capture and no restart; tile count is unaffected.

Source files
------------

// File: rtl/tile_scheduler.sv
// tile_scheduler: sequences overlapping n x n tiles from the input control unit to the engine.
// Define TILE_SCHEDULER_PERF_EN to build the engine back-pressure cycle counter.
module tile_scheduler #(
    parameter int M = 3,
    parameter int W = 512,
    parameter int H = 512,
    parameter int n = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_tile_valid,
    input  logic [M*n*n*8-1:0]    i_tile_data,
    input  logic                  i_engine_ready,
    input  logic                  i_engine_idle,
    output logic                  o_tile_valid,
    output logic [M*n*n*8-1:0]    o_tile_data,
    output logic [15:0]           o_tile_col,
    output logic [15:0]           o_tile_row,
    output logic                  o_last,
    output logic                  o_proc_finish,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [31:0]           o_stall_cycles
);
    localparam int S = n - 2;
    localparam int TILES_X = (W - n) / S + 1;
    localparam int TILES_Y = (H - n) / S + 1;
    localparam logic [15:0] LX = 16'(TILES_X - 1);
    localparam logic [15:0] LY = 16'(TILES_Y - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;
    logic full, overflow, xfer, start_ok, cap;
    logic [M*n*n*8-1:0] data;
    logic [15:0] col, row;

    assign xfer = full && i_engine_ready;
    assign start_ok = state == IDLE && i_start;
    assign o_last = full && col == LX && row == LY;
    // a tile arriving alongside the frame's final transfer belongs to no frame
    assign cap = state == RUN && i_tile_valid && (!full || xfer) && !(xfer && o_last);
    assign o_tile_valid = full;
    assign o_tile_data = data;
    assign o_tile_col = col;
    assign o_tile_row = row;
    assign o_overflow = overflow;
    assign o_proc_finish = state == DONE;
    assign o_busy = state == RUN || state == FLUSH;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (i_start ? RUN : IDLE) :
                   state == RUN   ? (xfer && o_last ? FLUSH : RUN) :
                   state == FLUSH ? (i_engine_idle ? DONE : FLUSH) : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            full <= 1'b0;
            data <= '0;
            col <= '0;
            row <= '0;
            overflow <= 1'b0;
        end else begin
            if (cap) begin
                full <= 1'b1;
                data <= i_tile_data;
            end else if (xfer) begin
                full <= 1'b0;
            end
            if (state == RUN && i_tile_valid && full && !xfer) overflow <= 1'b1;
            if (xfer) begin
                col <= col == LX ? '0 : col + 16'd1;
                row <= col == LX ? (row == LY ? '0 : row + 16'd1) : row;
            end
        end
    end

`ifdef TILE_SCHEDULER_PERF_EN
    logic [31:0] stall;
    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) stall <= '0;
        else if (full && !i_engine_ready && stall != 32'hFFFF_FFFF) stall <= stall + 32'd1;
    end
    assign o_stall_cycles = stall;
`else
    assign o_stall_cycles = '0;
`endif
endmodule
